// File: rtl/keyboard.sv
// ---------------------------------------------------------------------------
// keyboard
//   Translates PS/2 set-2 scan codes into a 40-key, 8-row by 5-column key
//   matrix of the kind scanned by a Z80-era CPU. The CPU reads the matrix by
//   pulling address lines A15:A8 low (row) and sampling D4:D0 (cols).
//
//   Some PC keys have no key of their own in the matrix. They are reported as
//   two matrix keys at once (e.g. backspace = CAPS SHIFT + 0). Every key that
//   can hold a shared matrix bit has its own source flop, and the shared
//   matrix bit is the OR of those flops. Releasing one PC key therefore never
//   drops a bit that another held key still needs.
//
// Parameters
//   CURSORS  1: backspace and the arrow keys map to CS+digit; 0: ignored
//
// Ports
//   clock    system clock, all state on the rising edge
//   reset    asynchronous active-low reset
//   strb     one-cycle pulse, code is valid in that cycle
//   code     PS/2 set-2 scan code byte
//   row      A15:A8, active-low half-row select
//   cols     D4:D0, active-low key columns (combinational from state)
//   nmi      high while F5 is held
//   boot     high while Ctrl+Alt+Del are all held
// ---------------------------------------------------------------------------
module keyboard #(
  parameter int CURSORS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] code,
  input  logic [7:0] row,
  output logic [4:0] cols,
  output logic       nmi,
  output logic       boot
);

  // Prefix decoder states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_EXTBRK = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;

  // Matrix bit positions (row*5 + column) of the shared keys
  localparam int IDX_CS = 0;
  localparam int IDX_5  = 19;
  localparam int IDX_0  = 20;
  localparam int IDX_8  = 22;
  localparam int IDX_7  = 23;
  localparam int IDX_6  = 24;

  // Non-extended codes with a single dedicated matrix key.
  // Returns {hit, index}. CS and SS are handled separately.
  function automatic logic [6:0] map_key(input logic [7:0] c);
    logic [6:0] r;
    case (c)
      8'h1A: r = {1'b1, 6'd1};   // Z
      8'h22: r = {1'b1, 6'd2};   // X
      8'h21: r = {1'b1, 6'd3};   // C
      8'h2A: r = {1'b1, 6'd4};   // V
      8'h1C: r = {1'b1, 6'd5};   // A
      8'h1B: r = {1'b1, 6'd6};   // S
      8'h23: r = {1'b1, 6'd7};   // D
      8'h2B: r = {1'b1, 6'd8};   // F
      8'h34: r = {1'b1, 6'd9};   // G
      8'h15: r = {1'b1, 6'd10};  // Q
      8'h1D: r = {1'b1, 6'd11};  // W
      8'h24: r = {1'b1, 6'd12};  // E
      8'h2D: r = {1'b1, 6'd13};  // R
      8'h2C: r = {1'b1, 6'd14};  // T
      8'h16: r = {1'b1, 6'd15};  // 1
      8'h1E: r = {1'b1, 6'd16};  // 2
      8'h26: r = {1'b1, 6'd17};  // 3
      8'h25: r = {1'b1, 6'd18};  // 4
      8'h2E: r = {1'b1, 6'd19};  // 5
      8'h45: r = {1'b1, 6'd20};  // 0
      8'h46: r = {1'b1, 6'd21};  // 9
      8'h3E: r = {1'b1, 6'd22};  // 8
      8'h3D: r = {1'b1, 6'd23};  // 7
      8'h36: r = {1'b1, 6'd24};  // 6
      8'h4D: r = {1'b1, 6'd25};  // P
      8'h44: r = {1'b1, 6'd26};  // O
      8'h43: r = {1'b1, 6'd27};  // I
      8'h3C: r = {1'b1, 6'd28};  // U
      8'h35: r = {1'b1, 6'd29};  // Y
      8'h5A: r = {1'b1, 6'd30};  // ENTER
      8'h4B: r = {1'b1, 6'd31};  // L
      8'h42: r = {1'b1, 6'd32};  // K
      8'h3B: r = {1'b1, 6'd33};  // J
      8'h33: r = {1'b1, 6'd34};  // H
      8'h29: r = {1'b1, 6'd35};  // SPACE
      8'h14: r = {1'b1, 6'd36};  // SS (left ctrl)
      8'h3A: r = {1'b1, 6'd37};  // M
      8'h31: r = {1'b1, 6'd38};  // N
      8'h32: r = {1'b1, 6'd39};  // B
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [39:0] key_q, key_d;       // keys with a single PC source
  logic        lshift_q, lshift_d;
  logic        rshift_q, rshift_d;
  logic        bksp_q, bksp_d;
  logic [3:0]  cur_q, cur_d;       // 0 left, 1 down, 2 up, 3 right
  logic        ctrl_l_q, ctrl_l_d;
  logic        ctrl_r_q, ctrl_r_d;
  logic        alt_l_q, alt_l_d;
  logic        alt_r_q, alt_r_d;
  logic        del_q, del_d;
  logic        nmi_q, nmi_d;
  logic        boot_q, boot_d;

  logic        mk_s;
  logic        ext_s;
  logic [6:0]  hit_s;
  logic [39:0] mat_s;
  logic [4:0]  sel_s;

  // Next-state: prefix decoding, pause skipping and key source updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    bksp_d   = bksp_q;
    cur_d    = cur_q;
    ctrl_l_d = ctrl_l_q;
    ctrl_r_d = ctrl_r_q;
    alt_l_d  = alt_l_q;
    alt_r_d  = alt_r_q;
    del_d    = del_q;
    nmi_d    = nmi_q;
    mk_s     = (state_q == ST_IDLE) || (state_q == ST_EXT);
    ext_s    = (state_q == ST_EXT)  || (state_q == ST_EXTBRK);
    hit_s    = map_key(code);

    if (strb) begin
      if (state_q == ST_PAUSE) begin
        // The Pause make sequence is E1 plus seven more bytes; swallow them
        if (cnt_q == 3'd6) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end else begin
        case (code)
          8'hE1: begin
            state_d = ST_PAUSE;
            cnt_d   = 3'd0;
          end
          8'hAA: begin
            // Keyboard self-test passed: it was re-plugged or reset
            state_d  = ST_IDLE;
            key_d    = 40'd0;
            lshift_d = 1'b0;
            rshift_d = 1'b0;
            bksp_d   = 1'b0;
            cur_d    = 4'd0;
            ctrl_l_d = 1'b0;
            ctrl_r_d = 1'b0;
            alt_l_d  = 1'b0;
            alt_r_d  = 1'b0;
            del_d    = 1'b0;
            nmi_d    = 1'b0;
          end
          8'hFA, 8'hFE, 8'hEE: begin
            state_d = state_q;
          end
          8'hE0: begin
            if (state_q == ST_IDLE) begin
              state_d = ST_EXT;
            end else if (state_q == ST_BRK) begin
              state_d = ST_EXTBRK;
            end else begin
              state_d = state_q;
            end
          end
          8'hF0: begin
            if (state_q == ST_IDLE) begin
              state_d = ST_BRK;
            end else if (state_q == ST_EXT) begin
              state_d = ST_EXTBRK;
            end else begin
              state_d = state_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            if (!ext_s) begin
              if (hit_s[6]) begin
                key_d[hit_s[5:0]] = mk_s;
              end else begin
                key_d = key_q;
              end
              case (code)
                8'h12: lshift_d = mk_s;
                8'h59: rshift_d = mk_s;
                8'h14: ctrl_l_d = mk_s;
                8'h11: alt_l_d  = mk_s;
                8'h03: nmi_d    = mk_s;
                8'h66: begin
                  if (CURSORS != 0) begin
                    bksp_d = mk_s;
                  end else begin
                    bksp_d = bksp_q;
                  end
                end
                default: begin
                  lshift_d = lshift_q;
                end
              endcase
            end else begin
              case (code)
                8'h14: ctrl_r_d = mk_s;
                8'h11: alt_r_d  = mk_s;
                8'h71: del_d    = mk_s;
                8'h6B, 8'h72, 8'h75, 8'h74: begin
                  if (CURSORS != 0) begin
                    case (code)
                      8'h6B:   cur_d[0] = mk_s;
                      8'h72:   cur_d[1] = mk_s;
                      8'h75:   cur_d[2] = mk_s;
                      default: cur_d[3] = mk_s;
                    endcase
                  end else begin
                    cur_d = cur_q;
                  end
                end
                default: begin
                  del_d = del_q;
                end
              endcase
            end
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    boot_d = (ctrl_l_d | ctrl_r_d) & (alt_l_d | alt_r_d) & del_d;
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      key_q    <= 40'd0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      bksp_q   <= 1'b0;
      cur_q    <= 4'd0;
      ctrl_l_q <= 1'b0;
      ctrl_r_q <= 1'b0;
      alt_l_q  <= 1'b0;
      alt_r_q  <= 1'b0;
      del_q    <= 1'b0;
      nmi_q    <= 1'b0;
      boot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      bksp_q   <= bksp_d;
      cur_q    <= cur_d;
      ctrl_l_q <= ctrl_l_d;
      ctrl_r_q <= ctrl_r_d;
      alt_l_q  <= alt_l_d;
      alt_r_q  <= alt_r_d;
      del_q    <= del_d;
      nmi_q    <= nmi_d;
      boot_q   <= boot_d;
    end
  end

  // Visible matrix: dedicated keys plus OR of every source of a shared key
  always_comb begin
    mat_s         = key_q;
    mat_s[IDX_CS] = lshift_q | rshift_q | bksp_q | (|cur_q);
    mat_s[IDX_0]  = key_q[IDX_0] | bksp_q;
    mat_s[IDX_5]  = key_q[IDX_5] | cur_q[0];
    mat_s[IDX_6]  = key_q[IDX_6] | cur_q[1];
    mat_s[IDX_7]  = key_q[IDX_7] | cur_q[2];
    mat_s[IDX_8]  = key_q[IDX_8] | cur_q[3];
  end

  // Column read-back: OR of all selected rows, inverted onto the data bus
  always_comb begin
    sel_s = 5'd0;
    for (int r = 0; r < 8; r++) begin
      if (!row[r]) begin
        sel_s = sel_s | mat_s[r*5 +: 5];
      end else begin
        sel_s = sel_s;
      end
    end
    cols = ~sel_s;
  end

  assign nmi  = nmi_q;
  assign boot = boot_q;

endmodule

// File: tb/tb_keyboard.sv
// Self-checking bench for keyboard: a table of {byte, row, expected outputs}
// records applied in order, followed by hand-written pause and reset cases.
module tb_keyboard;

  logic       clock;
  logic       reset;
  logic       strb;
  logic [7:0] code;
  logic [7:0] row;
  logic [4:0] cols;
  logic       nmi;
  logic       boot;

  int vec_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic       do_strb;
    logic [7:0] code;
    logic [7:0] row;
    logic [4:0] cols;
    logic       nmi;
    logic       boot;
  } vec_t;

  vec_t vecs[$];

  keyboard #(.CURSORS(1)) dut (
    .clock (clock),
    .reset (reset),
    .strb  (strb),
    .code  (code),
    .row   (row),
    .cols  (cols),
    .nmi   (nmi),
    .boot  (boot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic s, input logic [7:0] c, input logic [7:0] r,
                     input logic [4:0] cl, input logic n, input logic b);
    vec_t v;
    v.do_strb = s;
    v.code    = c;
    v.row     = r;
    v.cols    = cl;
    v.nmi     = n;
    v.boot    = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] r,
                       input logic [4:0] ecols, input logic en, input logic eb);
    row = r;
    #1;
    vec_count++;
    if (cols !== ecols || nmi !== en || boot !== eb) begin
      fail_count++;
      $display("FAIL %s: row=%h got cols=%b nmi=%b boot=%b, want cols=%b nmi=%b boot=%b",
               name, r, cols, nmi, boot, ecols, en, eb);
    end
  endtask

  // One strobed byte; returns at the falling edge after it was sampled
  task automatic send(input logic [7:0] c);
    @(negedge clock);
    strb = 1'b1;
    code = c;
    @(negedge clock);
    strb = 1'b0;
    code = 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("async_reset", 8'h00, 5'b11111, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    strb  = 1'b0;
    code  = 8'h00;
    row   = 8'hFF;

    // Basic make/break of A, row 1
    add(1'b0, 8'h00, 8'h00, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'h1C, 8'hFD, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFD, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h1C, 8'hFD, 5'b11111, 1'b0, 1'b0);
    // Shift and left arrow share CS
    add(1'b1, 8'h12, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h6B, 8'hF7, 5'b01111, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h12, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h6B, 8'hF7, 5'b11111, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFE, 5'b11111, 1'b0, 1'b0);
    // Two rows selected together
    add(1'b1, 8'h1A, 8'hFE, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'h15, 8'hFA, 5'b11100, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFB, 5'b11110, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFF, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFF, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'h1A, 8'hFE, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFB, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h15, 8'hFB, 5'b11111, 1'b0, 1'b0);
    // F5 drives nmi
    add(1'b1, 8'h03, 8'hFF, 5'b11111, 1'b1, 1'b0);
    add(1'b1, 8'hF0, 8'hFF, 5'b11111, 1'b1, 1'b0);
    add(1'b1, 8'h03, 8'hFF, 5'b11111, 1'b0, 1'b0);
    // Ctrl+Alt+Del
    add(1'b1, 8'h14, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'h11, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'h71, 8'h7F, 5'b11101, 1'b0, 1'b1);
    add(1'b1, 8'hE0, 8'h7F, 5'b11101, 1'b0, 1'b1);
    add(1'b1, 8'hF0, 8'h7F, 5'b11101, 1'b0, 1'b1);
    add(1'b1, 8'h71, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'h71, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'h7F, 5'b11101, 1'b0, 1'b0);
    add(1'b1, 8'h14, 8'h7F, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'h7F, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'h11, 8'h7F, 5'b11111, 1'b0, 1'b0);
    // Typematic repeat and release of an unpressed key
    add(1'b1, 8'h1C, 8'hFD, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h1C, 8'hFD, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFD, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h1C, 8'hFD, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFD, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'h1B, 8'hFD, 5'b11111, 1'b0, 1'b0);
    // Unmapped code, ack inside an extended sequence, repeated E0
    add(1'b1, 8'h0D, 8'h00, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'h00, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hFA, 8'h00, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'h75, 8'hEF, 5'b10111, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'h00, 5'b10110, 1'b0, 1'b0);
    add(1'b1, 8'hE0, 8'h00, 5'b10110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'h00, 5'b10110, 1'b0, 1'b0);
    add(1'b1, 8'h75, 8'h00, 5'b11111, 1'b0, 1'b0);
    // Backspace and a plain 0 share the 0 key
    add(1'b1, 8'h45, 8'hEF, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h66, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hEF, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h66, 8'hEF, 5'b11110, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'hFE, 5'b11111, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hEF, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h45, 8'hEF, 5'b11111, 1'b0, 1'b0);
    // Right shift
    add(1'b1, 8'h59, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'hF0, 8'hFE, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h59, 8'hFE, 5'b11111, 1'b0, 1'b0);
    // Self-test pass clears everything held
    add(1'b1, 8'h1C, 8'h00, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h29, 8'h7F, 5'b11110, 1'b0, 1'b0);
    add(1'b1, 8'h03, 8'h00, 5'b11110, 1'b1, 1'b0);
    add(1'b1, 8'hAA, 8'h00, 5'b11111, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    check("reset_idle", 8'hFF, 5'b11111, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_strb) begin
        send(vecs[i].code);
      end else begin
        @(negedge clock);
      end
      check($sformatf("vec%0d", i), vecs[i].row, vecs[i].cols,
            vecs[i].nmi, vecs[i].boot);
    end

    // Pause sequence: nothing inside it may reach the matrix
    begin
      logic [7:0] pseq [8];
      pseq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) begin
        send(pseq[i]);
        check($sformatf("pause%0d", i), 8'h00, 5'b11111, 1'b0, 1'b0);
      end
      send(8'h1C);
      check("after_pause_a", 8'hFD, 5'b11110, 1'b0, 1'b0);
      check("after_pause_all", 8'h00, 5'b11110, 1'b0, 1'b0);
    end

    // Reset with A held and after an E0 prefix: 1C must decode as plain A
    send(8'hE0);
    pulse_reset();
    send(8'h1C);
    check("reset_mid_ext", 8'hFD, 5'b11110, 1'b0, 1'b0);

    // Reset in the middle of a pause sequence
    send(8'hE1);
    send(8'h14);
    pulse_reset();
    send(8'h1C);
    check("reset_mid_pause", 8'h00, 5'b11110, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/keyboard.md
KEYBOARD -- requirements
Module: keyboard

Interface
REQ-001 SHALL have parameter CURSORS, default 1, enabling composite mapping of cursor keys and backspace (0 = those codes ignored).
REQ-002 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port strb  input  1  one-clock pulse; code valid this cycle (from PS/2 receiver).
REQ-005 SHALL have port code  input  8  PS/2 set-2 scan code byte.
REQ-006 SHALL have port row  input  8  CPU address A15:A8, active-low half-row select.
REQ-007 SHALL have port cols  output  5  key columns D4:D0, active-low.
REQ-008 SHALL have port nmi  output  1  high while F5 held.
REQ-009 SHALL have port boot  output  1  high while Ctrl+Alt+Del all held.

Function
REQ-010 SHALL hold a 40-bit registered matrix key[r][c] (1 = pressed), r = 0..7 (A8..A15), c = 0..4 (D0..D4).
REQ-011 SHALL use rows: 0 CS Z X C V; 1 A S D F G; 2 Q W E R T; 3 1 2 3 4 5; 4 0 9 8 7 6; 5 P O I U Y; 6 ENTER L K J H; 7 SPACE SS M N B (listed D0..D4).
REQ-012 SHALL map letters, digits (main row), Enter 5A, Space 29 to their matrix bits; left shift 12 and right shift 59 to CS; left ctrl 14 to SS.
REQ-013 SHALL decode with prefix state machine: IDLE, EXT (after E0), BRK (after F0), EXTBRK (E0 then F0), PAUSE; all transitions only on strb.
REQ-014 SHALL on strb code E0 go IDLE->EXT, BRK->EXTBRK (ignored in EXT/EXTBRK).
REQ-015 SHALL on strb code F0 go IDLE->BRK, EXT->EXTBRK.
REQ-016 SHALL on any other code apply action (press if not break, release if break, ext = EXT/EXTBRK) then return to IDLE.
REQ-017 SHALL on code E1 enter PAUSE and discard the next 7 strobes via 3-bit counter, then IDLE; no matrix change.
REQ-018 SHALL on code AA (BAT ok) release all keys and return to IDLE; codes FA, FE, EE ignored, state unchanged.
REQ-019 SHALL ignore unmapped codes (state still returns to IDLE).
REQ-020 SHALL update matrix/nmi/boot on the clock edge at which strb is sampled (visible next cycle).
REQ-021 SHALL treat repeated make (typematic) as idempotent and release of an unpressed key as no-op.
REQ-022 SHALL, when CURSORS=1, map backspace 66 -> CS+0, E0 6B -> CS+5, E0 72 -> CS+6, E0 75 -> CS+7, E0 74 -> CS+8.
REQ-023 SHALL keep one source bit per CS contributor (lshift, rshift, bksp, 4 cursors); CS = OR of them; same OR scheme for digit bits shared with composites.
REQ-024 SHALL not release CS while any other CS source is still held.
REQ-025 SHALL compute cols[c] = NOT(OR over r with row[r]=0 of key[r][c]), combinational from registered state, zero latency from row.
REQ-026 SHALL give cols = 11111 when row = FF; multiple low row bits combine by OR.
REQ-027 SHALL drive nmi from F5 (03) held; boot = ctrl(14 or E0 14) AND alt(11 or E0 11) AND del (E0 71) held, registered.
REQ-028 SHALL ignore non-extended 71 (keypad .) for boot.

Reset
REQ-029 SHALL on reset low asynchronously clear matrix, all source bits, nmi, boot, pause counter; state = IDLE; cols = 11111.
REQ-030 SHALL on reset mid-sequence (e.g. after E0 or in PAUSE) discard the partial sequence; first byte after release is decoded from IDLE.

Verification
REQ-031 SHALL cover: strb 1C, row FD -> cols 11110 next cycle; strb F0,1C -> cols 11111.
REQ-032 SHALL cover: 12 make, E0 6B make, 12 break, row FE -> cols 11110 (CS still held); E0 F0 6B, row F7 -> cols 11111.
REQ-033 SHALL cover: E1 14 77 E1 F0 14 F0 77 then 1C -> only A pressed; no spurious keys during pause.
REQ-034 SHALL cover: 14, 11, E0 71 makes -> boot 1; E0 F0 71 -> boot 0; 14, 11, 71 -> boot 0.
REQ-035 SHALL cover: keys 1C, 29 held, strb AA -> row 00 gives cols 11111; reset asserted after E0 then 1C -> A pressed (not extended).
